// File: rtl/lsu_pkg.sv
// Shared types for the LSU dcache issue stage: opcodes, access sizes,
// per-entry FIFO and outstanding-load records, and the misalignment rule.
package lsu_pkg;

  localparam int LSU_XLEN      = 64;
  localparam int LSU_VADDR_W   = 32;
  localparam int LSU_ROB_IDX_W = 2;

  localparam logic LSU_LD = 1'b0;
  localparam logic LSU_ST = 1'b1;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  typedef struct packed {
    logic                     opcode;
    logic [LSU_VADDR_W-1:0]   addr;
    logic [2:0]               typ;
    logic [LSU_XLEN-1:0]      st_data;
    logic [LSU_ROB_IDX_W-1:0] rob_idx;
    logic                     misalign;
  } lsu_fifo_entry_t;

  typedef struct packed {
    logic       valid;
    logic       squashed;
    logic [2:0] typ;
  } outst_entry_t;

  // An access is misaligned when any address bit below its size is set.
  function automatic logic is_misaligned(input logic [LSU_VADDR_W-1:0] addr,
                                         input logic [1:0]             size);
    logic r;
    case (lsu_size_e'(size))
      SZ_B:    r = 1'b0;
      SZ_H:    r = addr[0];
      SZ_W:    r = |addr[1:0];
      default: r = |addr[2:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// Load data extension: sign- or zero-extends B/H/W return data to XLEN;
// doubleword data passes through untouched.
module lsu_ld_align
  import lsu_pkg::*;
#(
  parameter int XLEN = LSU_XLEN
) (
  input  logic [2:0]      type_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] data_o
);

  logic sext;

  always_comb begin
    sext   = ~type_i[2];
    data_o = data_i;
    case (lsu_size_e'(type_i[1:0]))
      SZ_B:    data_o = {{(XLEN-8){sext & data_i[7]}},   data_i[7:0]};
      SZ_H:    data_o = {{(XLEN-16){sext & data_i[15]}}, data_i[15:0]};
      SZ_W:    data_o = {{(XLEN-32){sext & data_i[31]}}, data_i[31:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/lsu_dcache_issue.sv
// In-order load/store issue stage: FIFO of memory ops, dcache dispatch,
// outstanding-load table with out-of-order responses, registered ROB writeback.
module lsu_dcache_issue
  import lsu_pkg::*;
#(
  parameter int XLEN      = LSU_XLEN,
  parameter int VADDR_W   = LSU_VADDR_W,
  parameter int ROB_IDX_W = LSU_ROB_IDX_W,
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic                 lsu_opcode_i,
  input  logic [VADDR_W-1:0]   lsu_addr_i,
  input  logic [2:0]           lsu_type_i,
  input  logic [XLEN-1:0]      lsu_st_data_i,
  input  logic [ROB_IDX_W-1:0] lsu_rob_idx_i,
  output logic                 dc_req_valid_o,
  input  logic                 dc_req_ready_i,
  output logic                 dc_opcode_o,
  output logic [VADDR_W-1:0]   dc_addr_o,
  output logic [2:0]           dc_type_o,
  output logic [XLEN-1:0]      dc_st_data_o,
  output logic [ROB_IDX_W-1:0] dc_rob_idx_o,
  input  logic                 dc_resp_valid_i,
  output logic                 dc_resp_ready_o,
  input  logic [XLEN-1:0]      dc_ld_data_i,
  input  logic [ROB_IDX_W-1:0] dc_rob_idx_i,
  output logic                 wb_valid_o,
  output logic [ROB_IDX_W-1:0] wb_rob_idx_o,
  output logic [XLEN-1:0]      wb_data_o,
  output logic                 wb_exc_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int NTAG = 1 << ROB_IDX_W;
  localparam int CW   = $clog2(MAX_OUTST + 1);

  lsu_fifo_entry_t fifo_q [DEPTH];
  lsu_fifo_entry_t fifo_d [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;

  outst_entry_t    tbl_q [NTAG];
  outst_entry_t    tbl_d [NTAG];
  logic [CW-1:0]   cnt_q, cnt_d;

  logic                 wb_valid_q, wb_valid_d;
  logic [ROB_IDX_W-1:0] wb_idx_q, wb_idx_d;
  logic [XLEN-1:0]      wb_data_q, wb_data_d;
  logic                 wb_exc_q, wb_exc_d;

  lsu_fifo_entry_t head;
  lsu_fifo_entry_t new_ent;
  outst_entry_t    resp_ent;
  logic            head_vld, full, enq, deq;
  logic            resp_hit, tag_busy, req_vld, hs, ld_issue, st_done, retire_exc;
  logic [CW-1:0]   cnt_eff;
  logic [XLEN-1:0] ld_ext;

  lsu_ld_align #(.XLEN(XLEN)) u_align (
    .type_i (resp_ent.typ),
    .data_i (dc_ld_data_i),
    .data_o (ld_ext)
  );

  // FIFO status and the head/response lookups.
  always_comb begin
    head     = fifo_q[rd_ptr_q[AW-1:0]];
    head_vld = (wr_ptr_q != rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    resp_ent = tbl_q[dc_rob_idx_i];
    resp_hit = dc_resp_valid_i & resp_ent.valid;
  end

  // Dispatch. Valid/ready: a request transfers on any cycle where
  // dc_req_valid_o and dc_req_ready_i are both high; a same-cycle response
  // frees its slot and tag before the head load is considered.
  always_comb begin
    cnt_eff    = cnt_q - CW'(resp_hit);
    tag_busy   = tbl_q[head.rob_idx].valid & ~(resp_hit & (dc_rob_idx_i == head.rob_idx));
    req_vld    = 1'b0;
    retire_exc = 1'b0;
    if (head_vld) begin
      if (head.misalign) begin
        retire_exc = ~dc_resp_valid_i;
      end else if (head.opcode == LSU_ST) begin
        req_vld = ~dc_resp_valid_i;
      end else begin
        req_vld = (cnt_eff < CW'(MAX_OUTST)) & ~tag_busy;
      end
    end
    hs       = req_vld & dc_req_ready_i;
    ld_issue = hs & (head.opcode == LSU_LD);
    st_done  = hs & (head.opcode == LSU_ST);
    deq      = hs | retire_exc;
    enq      = lsu_valid_i & ~full & ~flush_i;
  end

  always_comb begin
    new_ent.opcode   = lsu_opcode_i;
    new_ent.addr     = lsu_addr_i;
    new_ent.typ      = lsu_type_i;
    new_ent.st_data  = lsu_st_data_i;
    new_ent.rob_idx  = lsu_rob_idx_i;
    new_ent.misalign = is_misaligned(lsu_addr_i, lsu_type_i[1:0]);

    fifo_d = fifo_q;
    if (enq) fifo_d[wr_ptr_q[AW-1:0]] = new_ent;
    wr_ptr_d = wr_ptr_q + (AW+1)'(enq);
    rd_ptr_d = flush_i ? wr_ptr_q : rd_ptr_q + (AW+1)'(deq);
  end

  // Response clears before issue sets, so a tag may be freed and reissued at once.
  always_comb begin
    tbl_d = tbl_q;
    if (resp_hit) tbl_d[dc_rob_idx_i] = '0;
    if (ld_issue) tbl_d[head.rob_idx] = '{valid: 1'b1, squashed: 1'b0, typ: head.typ};
    if (flush_i) begin
      for (int i = 0; i < NTAG; i++) begin
        if (tbl_d[i].valid) tbl_d[i].squashed = 1'b1;
      end
    end
    cnt_d = cnt_q - CW'(resp_hit) + CW'(ld_issue);
  end

  always_comb begin
    wb_valid_d = 1'b0;
    wb_idx_d   = '0;
    wb_data_d  = '0;
    wb_exc_d   = 1'b0;
    if (!flush_i) begin
      if (resp_hit && !resp_ent.squashed) begin
        wb_valid_d = 1'b1;
        wb_idx_d   = dc_rob_idx_i;
        wb_data_d  = ld_ext;
      end else if (st_done) begin
        wb_valid_d = 1'b1;
        wb_idx_d   = head.rob_idx;
      end else if (retire_exc) begin
        wb_valid_d = 1'b1;
        wb_idx_d   = head.rob_idx;
        wb_exc_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      for (int i = 0; i < NTAG; i++)  tbl_q[i]  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_idx_q   <= '0;
      wb_data_q  <= '0;
      wb_exc_q   <= 1'b0;
    end else begin
      fifo_q     <= fifo_d;
      tbl_q      <= tbl_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_idx_q   <= wb_idx_d;
      wb_data_q  <= wb_data_d;
      wb_exc_q   <= wb_exc_d;
    end
  end

  assign lsu_ready_o     = ~full;
  assign dc_req_valid_o  = req_vld;
  assign dc_opcode_o     = head.opcode;
  assign dc_addr_o       = head.addr;
  assign dc_type_o       = head.typ;
  assign dc_st_data_o    = head.st_data;
  assign dc_rob_idx_o    = head.rob_idx;
  assign dc_resp_ready_o = 1'b1;
  assign wb_valid_o      = wb_valid_q;
  assign wb_rob_idx_o    = wb_idx_q;
  assign wb_data_o       = wb_data_q;
  assign wb_exc_o        = wb_exc_q;

  // A response must always match a load we issued.
  resp_tag_known: assert property (@(posedge clk) disable iff (!rstn)
    dc_resp_valid_i |-> resp_ent.valid)
    else $error("dcache response for idle rob tag %0d", dc_rob_idx_i);

endmodule
